// File: rtl/stk_rsp_q_pkg.sv
// stk_rsp_q_pkg: shared constants and types for the per-engine response queue
package stk_rsp_q_pkg;
  localparam int CFG_ENGS_N = 4;
  localparam int RSP_Q_DEPTH = 4;
  localparam int RSP_DAT_W = 128;
  typedef logic [3:0] status_t;
  typedef struct packed {
    status_t status;
    logic [RSP_DAT_W-1:0] dat;
  } rsp_q_ent_t;
  typedef logic [$clog2(RSP_Q_DEPTH+1)-1:0] rsp_q_cnt_t;
endpackage

// File: rtl/stk_rsp_q_if.sv
// stk_rsp_q_if: pipeline response beat, command credit and per-engine response bundle
interface stk_rsp_q_if
  import stk_rsp_q_pkg::*;
#(
  parameter int ENGS_N = CFG_ENGS_N,
  parameter int DAT_W = RSP_DAT_W,
  parameter int OCC_W = $clog2(RSP_Q_DEPTH+1)
);
  logic [ENGS_N-1:0] i_rsp_vld;
  logic [DAT_W-1:0] i_rsp_dat;
  status_t i_rsp_status;
  logic [ENGS_N-1:0] i_cmd_issue;
  logic [ENGS_N-1:0] o_cmd_permit;
  logic [ENGS_N-1:0] o_eng_rsp_vld;
  logic [ENGS_N-1:0] i_eng_rsp_rdy;
  logic [ENGS_N-1:0][DAT_W-1:0] o_eng_rsp_dat;
  status_t [ENGS_N-1:0] o_eng_rsp_status;
  logic [ENGS_N-1:0][OCC_W-1:0] o_eng_occ;
  logic [ENGS_N-1:0] o_eng_err;
  modport slave (
    input i_rsp_vld, i_rsp_dat, i_rsp_status, i_cmd_issue, i_eng_rsp_rdy,
    output o_cmd_permit, o_eng_rsp_vld, o_eng_rsp_dat, o_eng_rsp_status, o_eng_occ, o_eng_err
  );
  modport master (
    output i_rsp_vld, i_rsp_dat, i_rsp_status, i_cmd_issue, i_eng_rsp_rdy,
    input o_cmd_permit, o_eng_rsp_vld, o_eng_rsp_dat, o_eng_rsp_status, o_eng_occ, o_eng_err
  );
endinterface

// File: rtl/stk_rsp_q_eng.sv
// stk_rsp_q_eng: single-engine response FIFO with credit counter and sticky error
module stk_rsp_q_eng
  import stk_rsp_q_pkg::*;
#(
  parameter int DEPTH = RSP_Q_DEPTH,
  parameter int DAT_W = RSP_DAT_W
) (
  input  logic clk,
  input  logic arst_n,
  input  logic push_i,
  input  logic [DAT_W-1:0] dat_i,
  input  status_t status_i,
  input  logic issue_i,
  input  logic rdy_i,
  output logic vld_o,
  output logic [DAT_W-1:0] dat_o,
  output status_t status_o,
  output logic [$clog2(DEPTH+1)-1:0] occ_o,
  output logic permit_o,
  output logic err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam logic [OW-1:0] FULL = OW'(DEPTH);
  typedef struct packed {
    status_t status;
    logic [DAT_W-1:0] dat;
  } ent_t;
  ent_t mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [OW-1:0] occ_q, occ_d, cnt_q, cnt_d;
  logic err_q, err_d, permit_q;
  logic pop, acc, full, sat;
  assign vld_o = occ_q != '0;
  assign dat_o = mem_q[rd_q].dat;
  assign status_o = mem_q[rd_q].status;
  assign occ_o = occ_q;
  assign permit_o = permit_q;
  assign err_o = err_q;
  always_comb begin
    full = occ_q == FULL;
    sat = cnt_q == FULL;
    pop = vld_o & rdy_i;
    acc = push_i & (!full | pop);
    rd_d = rd_q + PW'(pop);
    wr_d = wr_q + PW'(acc);
    occ_d = occ_q + OW'(acc) - OW'(pop);
    cnt_d = (issue_i == pop) ? cnt_q : issue_i ? (sat ? cnt_q : cnt_q + OW'(1)) : cnt_q - OW'(1);
    err_d = err_q | (push_i & full & !pop) | (issue_i & sat & !pop);
  end
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      occ_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      permit_q <= 1'b1;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      permit_q <= cnt_d < FULL;
    end
  end
  always_ff @(posedge clk) if (acc) mem_q[wr_q] <= '{status: status_i, dat: dat_i};
  a_cnt_ge_occ: assert property (@(posedge clk) disable iff (!arst_n) cnt_q >= occ_q);
endmodule

// File: rtl/stk_rsp_q.sv
// stk_rsp_q: per-engine response queues and command credit permits behind the stack pipeline
module stk_rsp_q
  import stk_rsp_q_pkg::*;
#(
  parameter int ENGS_N = CFG_ENGS_N,
  parameter int DEPTH = RSP_Q_DEPTH,
  parameter int DAT_W = RSP_DAT_W
) (
  input logic clk,
  input logic arst_n,
  stk_rsp_q_if.slave bus
);
  for (genvar e = 0; e < ENGS_N; e++) begin : g_eng
    stk_rsp_q_eng #(.DEPTH(DEPTH), .DAT_W(DAT_W)) u_eng (
      .clk(clk),
      .arst_n(arst_n),
      .push_i(bus.i_rsp_vld[e]),
      .dat_i(bus.i_rsp_dat),
      .status_i(bus.i_rsp_status),
      .issue_i(bus.i_cmd_issue[e]),
      .rdy_i(bus.i_eng_rsp_rdy[e]),
      .vld_o(bus.o_eng_rsp_vld[e]),
      .dat_o(bus.o_eng_rsp_dat[e]),
      .status_o(bus.o_eng_rsp_status[e]),
      .occ_o(bus.o_eng_occ[e]),
      .permit_o(bus.o_cmd_permit[e]),
      .err_o(bus.o_eng_err[e])
    );
  end
  a_rsp_onehot0: assert property (@(posedge clk) disable iff (!arst_n) $onehot0(bus.i_rsp_vld));
endmodule

// File: tb/tb_stk_rsp_q.sv
// tb_stk_rsp_q: directed and randomized checks of stk_rsp_q against a queue-based model
module tb_stk_rsp_q;
  import stk_rsp_q_pkg::*;
  localparam int E = 4;
  localparam int D = 4;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;
  stk_rsp_q_if #(.ENGS_N(E), .DAT_W(128), .OCC_W(3)) bus ();
  stk_rsp_q #(.ENGS_N(E), .DEPTH(D), .DAT_W(128)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));
  rsp_q_ent_t mq [E][$];
  int mcnt [E];
  logic [E-1:0] merr;
  int n_cmp = 0;
  int n_bad = 0;
  task automatic idle();
    bus.i_rsp_vld = '0;
    bus.i_rsp_dat = '0;
    bus.i_rsp_status = '0;
    bus.i_cmd_issue = '0;
    bus.i_eng_rsp_rdy = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    for (int e = 0; e < E; e++) begin
      bit pop, full, push, iss;
      pop = mq[e].size() != 0 && bus.i_eng_rsp_rdy[e];
      full = mq[e].size() == D;
      push = bus.i_rsp_vld[e];
      iss = bus.i_cmd_issue[e];
      if (!arst_n) begin
        mq[e].delete();
        mcnt[e] = 0;
        merr[e] = 1'b0;
      end else begin
        if (push && full && !pop) merr[e] = 1'b1;
        if (iss && mcnt[e] == D && !pop) merr[e] = 1'b1;
        if (pop) void'(mq[e].pop_front());
        if (push && (!full || pop)) mq[e].push_back('{status: bus.i_rsp_status, dat: bus.i_rsp_dat});
        if (iss && !pop && mcnt[e] < D) mcnt[e]++;
        else if (pop && !iss) mcnt[e]--;
      end
    end
    #1;
  endtask
  task automatic test_reset();
    idle();
    arst_n = 1'b0;
    tick();
    tick();
    arst_n = 1'b1;
    tick();
    n_cmp++; if (bus.o_eng_rsp_vld !== 4'b0000) begin n_bad++; $display("FAIL reset_vld: got %b want 0000", bus.o_eng_rsp_vld); end
    n_cmp++; if (bus.o_cmd_permit !== 4'b1111) begin n_bad++; $display("FAIL reset_permit: got %b want 1111", bus.o_cmd_permit); end
    n_cmp++; if (bus.o_eng_occ !== 12'h000) begin n_bad++; $display("FAIL reset_occ: got %h want 000", bus.o_eng_occ); end
    n_cmp++; if (bus.o_eng_err !== 4'b0000) begin n_bad++; $display("FAIL reset_err: got %b want 0000", bus.o_eng_err); end
  endtask
  task automatic test_credit();
    for (int i = 0; i < 4; i++) begin
      bus.i_cmd_issue = 4'b0100;
      tick();
      n_cmp++; if (bus.o_cmd_permit !== (i < 3 ? 4'b1111 : 4'b1011)) begin n_bad++; $display("FAIL credit_permit[%0d]: got %b want %b", i, bus.o_cmd_permit, (i < 3 ? 4'b1111 : 4'b1011)); end
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.i_rsp_vld = 4'b0100;
      bus.i_rsp_dat = 128'(10 + i);
      bus.i_rsp_status = 4'(i);
      tick();
    end
    idle();
    n_cmp++; if (bus.o_eng_occ[2] !== 3'd4) begin n_bad++; $display("FAIL credit_occ: got %0d want 4", bus.o_eng_occ[2]); end
    n_cmp++; if (bus.o_eng_rsp_vld !== 4'b0100) begin n_bad++; $display("FAIL credit_vld: got %b want 0100", bus.o_eng_rsp_vld); end
    for (int i = 0; i < 4; i++) begin
      bus.i_eng_rsp_rdy = 4'b0100;
      n_cmp++; if (bus.o_eng_rsp_dat[2] !== 128'(10 + i)) begin n_bad++; $display("FAIL credit_dat[%0d]: got %h want %h", i, bus.o_eng_rsp_dat[2], 128'(10 + i)); end
      n_cmp++; if (bus.o_eng_rsp_status[2] !== 4'(i)) begin n_bad++; $display("FAIL credit_status[%0d]: got %h want %h", i, bus.o_eng_rsp_status[2], 4'(i)); end
      tick();
      if (i == 0) begin
        n_cmp++; if (bus.o_cmd_permit[2] !== 1'b1) begin n_bad++; $display("FAIL credit_permit_back: got %b want 1", bus.o_cmd_permit[2]); end
      end
    end
    idle();
    n_cmp++; if (bus.o_eng_rsp_vld[2] !== 1'b0) begin n_bad++; $display("FAIL credit_drained: got %b want 0", bus.o_eng_rsp_vld[2]); end
  endtask
  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      bus.i_cmd_issue = 4'b0001;
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.i_rsp_vld = 4'b0001;
      bus.i_rsp_dat = 128'(16 + i);
      tick();
    end
    bus.i_rsp_vld = 4'b0001;
    bus.i_rsp_dat = 128'(20);
    bus.i_eng_rsp_rdy = 4'b0001;
    bus.i_cmd_issue = 4'b0001;
    n_cmp++; if (bus.o_eng_rsp_dat[0] !== 128'(16)) begin n_bad++; $display("FAIL pp_oldest: got %h want 10", bus.o_eng_rsp_dat[0]); end
    tick();
    idle();
    n_cmp++; if (bus.o_eng_occ[0] !== 3'd4) begin n_bad++; $display("FAIL pp_occ: got %0d want 4", bus.o_eng_occ[0]); end
    n_cmp++; if (bus.o_eng_err[0] !== 1'b0) begin n_bad++; $display("FAIL pp_err: got %b want 0", bus.o_eng_err[0]); end
    for (int i = 0; i < 4; i++) begin
      bus.i_eng_rsp_rdy = 4'b0001;
      n_cmp++; if (bus.o_eng_rsp_dat[0] !== 128'(17 + i)) begin n_bad++; $display("FAIL pp_drain[%0d]: got %h want %h", i, bus.o_eng_rsp_dat[0], 128'(17 + i)); end
      tick();
    end
    idle();
    n_cmp++; if ({bus.o_eng_rsp_vld[0], bus.o_cmd_permit[0]} !== 2'b01) begin n_bad++; $display("FAIL pp_end vld/permit: got %b%b want 01", bus.o_eng_rsp_vld[0], bus.o_cmd_permit[0]); end
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      bus.i_cmd_issue = 4'b0010;
      tick();
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      bus.i_rsp_vld = 4'b0010;
      bus.i_rsp_dat = i < 4 ? 128'(32 + i) : 128'h99;
      tick();
    end
    idle();
    n_cmp++; if (bus.o_eng_occ[1] !== 3'd4) begin n_bad++; $display("FAIL ovf_occ: got %0d want 4", bus.o_eng_occ[1]); end
    n_cmp++; if (bus.o_eng_err[1] !== 1'b1) begin n_bad++; $display("FAIL ovf_err: got %b want 1", bus.o_eng_err[1]); end
    for (int i = 0; i < 4; i++) begin
      bus.i_eng_rsp_rdy = 4'b0010;
      n_cmp++; if (bus.o_eng_rsp_dat[1] !== 128'(32 + i)) begin n_bad++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, bus.o_eng_rsp_dat[1], 128'(32 + i)); end
      tick();
    end
    idle();
    n_cmp++; if ({bus.o_eng_rsp_vld[1], bus.o_eng_err[1]} !== 2'b01) begin n_bad++; $display("FAIL ovf_end vld/err: got %b%b want 01", bus.o_eng_rsp_vld[1], bus.o_eng_err[1]); end
  endtask
  task automatic test_wrap();
    int issued = 0;
    int pushed = 0;
    logic [127:0] got [$];
    for (int c = 0; c < 400 && got.size() < 20; c++) begin
      bus.i_cmd_issue = (issued < 20 && bus.o_cmd_permit[3]) ? 4'b1000 : 4'b0000;
      bus.i_rsp_vld = pushed < issued ? 4'b1000 : 4'b0000;
      bus.i_rsp_dat = 128'(256 + pushed);
      bus.i_eng_rsp_rdy = c % 2 == 0 ? 4'b1000 : 4'b0000;
      if (bus.o_eng_rsp_vld[3] && bus.i_eng_rsp_rdy[3]) got.push_back(bus.o_eng_rsp_dat[3]);
      if (bus.i_cmd_issue[3]) issued++;
      if (bus.i_rsp_vld[3]) pushed++;
      tick();
    end
    idle();
    n_cmp++; if (got.size() != 20) begin n_bad++; $display("FAIL wrap_count: got %0d want 20", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      n_cmp++; if (got[i] !== 128'(256 + i)) begin n_bad++; $display("FAIL wrap_order[%0d]: got %h want %h", i, got[i], 128'(256 + i)); end
    end
    n_cmp++; if (bus.o_eng_err[3] !== 1'b0) begin n_bad++; $display("FAIL wrap_err: got %b want 0", bus.o_eng_err[3]); end
  endtask
  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) begin
      bus.i_cmd_issue = 4'b0001;
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.i_rsp_vld = 4'b0001;
      bus.i_rsp_dat = 128'(48 + i);
      tick();
    end
    idle();
    n_cmp++; if ({bus.o_eng_occ[0], bus.o_cmd_permit[0]} !== {3'd3, 1'b0}) begin n_bad++; $display("FAIL mrst_pre occ/permit: got %0d/%b want 3/0", bus.o_eng_occ[0], bus.o_cmd_permit[0]); end
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    n_cmp++; if (bus.o_eng_rsp_vld[0] !== 1'b0) begin n_bad++; $display("FAIL mrst_vld: got %b want 0", bus.o_eng_rsp_vld[0]); end
    n_cmp++; if (bus.o_eng_occ[0] !== 3'd0) begin n_bad++; $display("FAIL mrst_occ: got %0d want 0", bus.o_eng_occ[0]); end
    n_cmp++; if (bus.o_cmd_permit !== 4'b1111) begin n_bad++; $display("FAIL mrst_permit: got %b want 1111", bus.o_cmd_permit); end
    n_cmp++; if (bus.o_eng_err !== 4'b0000) begin n_bad++; $display("FAIL mrst_err: got %b want 0000", bus.o_eng_err); end
  endtask
  task automatic test_random();
    idle();
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      int pe;
      for (int e = 0; e < E; e++) bus.i_cmd_issue[e] = mcnt[e] < D && $urandom_range(0, 1) == 1;
      pe = $urandom_range(0, E - 1);
      bus.i_rsp_vld = '0;
      if (mcnt[pe] > mq[pe].size() && $urandom_range(0, 2) != 0) bus.i_rsp_vld[pe] = 1'b1;
      bus.i_rsp_dat = {$urandom, $urandom, $urandom, $urandom};
      bus.i_rsp_status = 4'($urandom);
      bus.i_eng_rsp_rdy = 4'($urandom);
      tick();
      for (int e = 0; e < E; e++) begin
        n_cmp++; if (bus.o_eng_rsp_vld[e] !== (mq[e].size() != 0)) begin n_bad++; $display("FAIL rnd_vld c%0d e%0d: got %b want %b", c, e, bus.o_eng_rsp_vld[e], mq[e].size() != 0); end
        n_cmp++; if (bus.o_eng_occ[e] !== 3'(mq[e].size())) begin n_bad++; $display("FAIL rnd_occ c%0d e%0d: got %0d want %0d", c, e, bus.o_eng_occ[e], mq[e].size()); end
        n_cmp++; if (bus.o_cmd_permit[e] !== (mcnt[e] < D)) begin n_bad++; $display("FAIL rnd_permit c%0d e%0d: got %b want %b", c, e, bus.o_cmd_permit[e], mcnt[e] < D); end
        n_cmp++; if (bus.o_eng_err[e] !== merr[e]) begin n_bad++; $display("FAIL rnd_err c%0d e%0d: got %b want %b", c, e, bus.o_eng_err[e], merr[e]); end
        if (mq[e].size() != 0) begin
          n_cmp++; if ({bus.o_eng_rsp_status[e], bus.o_eng_rsp_dat[e]} !== mq[e][0]) begin n_bad++; $display("FAIL rnd_head c%0d e%0d: got %h want %h", c, e, {bus.o_eng_rsp_status[e], bus.o_eng_rsp_dat[e]}, mq[e][0]); end
        end
      end
    end
    idle();
  endtask
  initial begin
    idle();
    test_reset();
    test_credit();
    test_full_push_pop();
    test_overflow();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stk_rsp_q.md
Name: stk_rsp_q

Overview:
- Per-engine response queue and credit manager sitting directly downstream of the stack pipeline's writeback/response stage.
- Captures the pipeline's one-hot response beat (shared data/status bus) into a per-engine FIFO and presents each engine with an independent valid/ready response interface.
- Tracks per-engine credits (queued plus in-flight) and produces a per-engine command-permit vector. Upstream glue ANDs this vector into the pipeline's command-valid inputs, so the non-backpressurable response path can never overflow.

Parameters:
- ENGS_N, cfg_pkg::ENGS_N (4), number of engines.
- DEPTH, stk_pkg::RSP_Q_DEPTH (4), entries per engine FIFO; power of two, >=2.
- DAT_W, 128, response data width.

Ports:
- clk  in  1  clock
- arst_n  in  1  reset; synchronous, active-low
- i_rsp_vld  in  ENGS_N  response beat from pipeline, one-hot-or-zero
- i_rsp_dat  in  DAT_W  response data, shared across engines
- i_rsp_status  in  stk_pkg::status_t  response status, shared
- i_cmd_issue  in  ENGS_N  command accepted by pipeline for engine e (pipeline cmd ack)
- o_cmd_permit  out  ENGS_N  engine e may present a command
- o_eng_rsp_vld  out  ENGS_N  head entry valid per engine
- i_eng_rsp_rdy  in  ENGS_N  engine consumes head
- o_eng_rsp_dat  out  ENGS_N x DAT_W  head data per engine
- o_eng_rsp_status  out  ENGS_N x stk_pkg::status_t  head status per engine
- o_eng_occ  out  ENGS_N x $clog2(DEPTH+1)  FIFO occupancy per engine
- o_eng_err  out  ENGS_N  sticky protocol error per engine

Behaviour:
- Reset (arst_n=0 at posedge clk), per engine:
  - FIFO rd/wr pointers = 0; occ = 0; credit count cnt = 0; err = 0.
  - o_eng_rsp_vld = 0, o_cmd_permit = all 1s, o_eng_occ = 0, o_eng_err = 0.
  - o_eng_rsp_dat and o_eng_rsp_status are don't-care (entries are not reset).
- Reset mid-operation discards queued entries and in-flight credits. The pipeline must be reset in the same cycle.
- Push: i_rsp_vld[e]=1 writes {status,dat} at wr_ptr[e]. The entry is visible on o_eng_rsp_* at the next cycle (latency 1, no combinational bypass).
- Pop: o_eng_rsp_vld[e] & i_eng_rsp_rdy[e] advances rd_ptr[e]. The next entry is visible the next cycle.
- o_eng_rsp_vld[e] = (occ[e] != 0), registered state only. Data is stable while vld=1 and rdy=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from occ, not from pointer equality.
- Push and pop in the same cycle:
  - occ unchanged.
  - Legal when full: the pop frees the slot and the push is accepted.
  - When empty: the push completes, and the pop is ignored because vld was 0.
- Push when full without a simultaneous pop: the beat is dropped, occ is unchanged, and err[e] is set sticky.
- Credit count cnt[e], range 0..DEPTH, counts queued entries plus issued-but-unanswered commands:
  - +1 on i_cmd_issue[e]; -1 on pop[e]; the push itself does not change cnt.
  - Issue and pop in the same cycle: cnt unchanged.
- o_cmd_permit[e] = (cnt[e] < DEPTH), registered from next-state cnt. Permit therefore drops in the cycle after the issue that fills the last credit.
- i_cmd_issue[e] with cnt[e]==DEPTH: cnt saturates at DEPTH and err[e] is set.
- Pop taking cnt below occ cannot occur by construction; an assertion checks cnt >= occ.
- i_rsp_vld with more than one bit set:
  - Each flagged engine pushes the same beat.
  - An assertion fires ($onehot0).
  - This is not a functional mode.
- err is cleared only by reset.

Decomposition:
- stk_pkg additions:
  - RSP_Q_DEPTH constant.
  - rsp_q_ent_t packed struct {status_t status; logic [127:0] dat}.
  - rsp_q_cnt_t, width $clog2(RSP_Q_DEPTH+1).
- Sub-module stk_rsp_q_eng: single-engine FIFO + credit counter + err flag, instantiated ENGS_N times via generate.
- The top level only fans out the shared dat/status bus and packs the output vectors.

Test Plan:
- Reset, then idle: all o_eng_rsp_vld=0, o_cmd_permit=4'b1111, occ=0, err=0.
- Engine 2:
  - Issue 4 commands on consecutive cycles: permit[2] falls to 0 the cycle after the 4th issue; other permits stay 1.
  - Then responses 0xA..0xD arrive with rdy=0: occ[2]=4.
  - Then rdy=1 for 4 cycles: data 0xA,0xB,0xC,0xD in order; permit[2] returns to 1 after the first pop.
- Engine 0 full (occ=4): assert push and pop in the same cycle. Pop returns the oldest entry, occ stays 4, err[0]=0; the new beat appears last.
- Engine 1 full with rdy=0: an extra push is dropped, occ=4, err[1]=1 sticky; subsequent pops return the original 4 entries only.
- Wrap-around: stream 20 responses to engine 3 with rdy toggling 1/0 each cycle. Output sequence equals input order, with no loss or duplication.
- Reset mid-stream with engine 0 occ=3 and cnt=4: next cycle vld[0]=0, occ[0]=0, permit[0]=1, err[0]=0.
